// File: rtl/msg_rom_streamer_if.sv
// -----------------------------------------------------------------------------
// msg_rom_streamer_if
// Valid/ready stream bundle carrying message words from the ROM streamer to a
// downstream display/scroller.
//   s_data  : stream word (DATA_W bits)
//   s_valid : s_data holds a word for the consumer
//   s_ready : consumer accepts the word at this edge
//   s_last  : qualifies the final word of a message pass
// Modports: master (streamer side), slave (consumer side).
// -----------------------------------------------------------------------------
interface msg_rom_streamer_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] s_data;
    logic              s_valid;
    logic              s_ready;
    logic              s_last;

    modport master (
        output s_data,
        output s_valid,
        output s_last,
        input  s_ready
    );

    modport slave (
        input  s_data,
        input  s_valid,
        input  s_last,
        output s_ready
    );
endinterface

// File: rtl/msg_rom_streamer.sv
// -----------------------------------------------------------------------------
// msg_rom_streamer
// Block-ROM message source for the number-game display path. One message image
// is fixed at elaboration. A random-access synchronous read port serves legacy
// users; a stream engine plays the first len words to a valid/ready consumer,
// one-shot or looping, with abort.
// Ports:
//   clk      : system clock, rising edge
//   rst      : synchronous active-high reset
//   rd_addr  : random-access read address
//   rd_data  : registered rom[rd_addr] (0 when rd_addr >= DEPTH), 1-cycle latency
//   start    : single-cycle playback request, honoured only when idle
//   len      : message length in words, captured with start (clamped to DEPTH)
//   loop     : repeat playback; looked at on the last word's handshake
//   stop     : abort playback while fetching/presenting
//   busy     : engine not idle
//   done     : one-cycle pulse when a one-shot pass completes
//   s        : stream master (s_data, s_valid, s_ready, s_last)
// The ROM image is the built-in ramp (word i = 8'h10 + i).
// -----------------------------------------------------------------------------
module msg_rom_streamer #(
    parameter int    DATA_W    = 8,
    parameter int    DEPTH     = 16,
    parameter int    ADDR_W    = 4,
    parameter string INIT_FILE = "p2wins.mem"
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDR_W-1:0]   rd_addr,
    output logic [DATA_W-1:0]   rd_data,
    input  logic                start,
    input  logic [ADDR_W:0]     len,
    input  logic                loop,
    input  logic                stop,
    output logic                busy,
    output logic                done,
    msg_rom_streamer_if.master  s
);

    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    typedef logic [DATA_W-1:0] rom_t [DEPTH];

    function automatic rom_t load_image();
        rom_t img;
        for (int i = 0; i < DEPTH; i++) begin
            img[i] = DATA_W'(32'h10 + i);
        end
        return img;
    endfunction

    // NOTE: the ROM is never written and deliberately has no reset; a reset
    // port on the array would stop it mapping onto block RAM.
    (* rom_style = "block" *) logic [DATA_W-1:0] rom [DEPTH] = load_image();

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        PRESENT = 2'd2,
        FIN     = 2'd3
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W:0]   len_q;
    logic [ADDR_W:0]   len_clamped;
    logic              ptr_is_last;

    always_comb begin
        len_clamped = (len > DEPTH_L) ? DEPTH_L : len;
        // len_q is at least 1 whenever this is consulted (FETCH/PRESENT).
        ptr_is_last = ({1'b0, ptr} == (len_q - 1'b1));
    end

    // Random-access port: independent of the stream engine.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst) begin
            rd_data <= '0;
        end else if ({1'b0, rd_addr} < DEPTH_L) begin
            rd_data <= rom[rd_addr];
        end else begin
            rd_data <= '0;
        end
    end

    // Stream engine. Outputs are registered and assigned together with the
    // state they belong to, so they are valid for the whole cycle of that state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            len_q     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            s.s_data  <= '0;
            s.s_valid <= 1'b0;
            s.s_last  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    done      <= 1'b0;
                    s.s_valid <= 1'b0;
                    s.s_last  <= 1'b0;
                    if (start) begin
                        len_q <= len_clamped;
                        ptr   <= '0;
                        busy  <= 1'b1;
                        if (len_clamped == '0) begin
                            // Empty message: complete immediately.
                            state <= FIN;
                            done  <= 1'b1;
                        end else begin
                            state <= FETCH;
                        end
                    end
                end

                FETCH: begin
                    if (stop) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        // Stream-side synchronous ROM read.
                        s.s_data  <= rom[ptr];
                        s.s_last  <= ptr_is_last;
                        s.s_valid <= 1'b1;
                        state     <= PRESENT;
                    end
                end

                PRESENT: begin
                    if (stop) begin
                        // Abort wins over a coincident handshake.
                        state     <= IDLE;
                        busy      <= 1'b0;
                        s.s_valid <= 1'b0;
                        s.s_last  <= 1'b0;
                    end else if (s.s_ready) begin
                        s.s_valid <= 1'b0;
                        s.s_last  <= 1'b0;
                        if (!ptr_is_last) begin
                            ptr   <= ptr + 1'b1;
                            state <= FETCH;
                        end else if (loop) begin
                            ptr   <= '0;
                            state <= FETCH;
                        end else begin
                            state <= FIN;
                            done  <= 1'b1;
                        end
                    end
                end

                FIN: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
